// File: rtl/aes_key_sched_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : AES-128 key-schedule constants, S-box/Rcon helpers, FSM encoding
// Rev 1.0
// ============================================================================
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_EXPAND = ST_EXPAND,
    S_DONE   = ST_DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Byte 0 of the word sits in bits [0:7], matching the key bus ordering.
  function automatic logic [0:31] sub_word(input logic [0:31] w);
    return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_ctrl_key_round.sv
`default_nettype none
// ============================================================================
// aes_key_round : one combinational AES-128 key expansion round
// Rev 1.0
// ============================================================================
module aes_key_round
  import aes_pkg::*;
(
  input  logic [0:127] key,
  input  logic [3:0]   rnd,
  output logic [0:127] next_key
);

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] temp;
  logic [0:31] n0, n1, n2, n3;

  always_comb begin
    w0 = key[0:31];
    w1 = key[32:63];
    w2 = key[64:95];
    w3 = key[96:127];
    // RotWord moves byte 0 to the end, then SubWord and Rcon on the top byte.
    temp = sub_word({w3[8:31], w3[0:7]}) ^ {rcon(rnd), 24'h000000};
    n0 = temp ^ w0;
    n1 = n0 ^ w1;
    n2 = n1 ^ w2;
    n3 = n2 ^ w3;
    next_key = {n0, n1, n2, n3};
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// aes_key_sched_ctrl : sequential AES-128 key schedule, one round per clock,
// 11-entry round-key register file with registered read port. Rev 1.0
// ============================================================================
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR,
  parameter int KW = aes_pkg::KW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [0:KW-1] key_in,
  output logic          busy,
  output logic          done,
  output logic          keys_valid,
  input  logic [3:0]    rk_idx,
  output logic [0:KW-1] rk_out
);

  logic [1:0]    state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [0:KW-1] cur_key_q, cur_key_d;
  logic          done_q, done_d;
  logic          keys_valid_q, keys_valid_d;
  logic [0:KW-1] rk_out_q, rk_out_d;
  logic [0:KW-1] rk_q [0:NR];
  logic [0:KW-1] rk_d [0:NR];
  logic [0:KW-1] next_key;

  aes_key_round u_key_round (
    .key      (cur_key_q),
    .rnd      (rnd_q),
    .next_key (next_key)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    cur_key_d    = cur_key_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      rk_d[i] = rk_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d[0]      = key_in;
          cur_key_d    = key_in;
          rnd_d        = 4'd1;
          keys_valid_d = 1'b0;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rk_d[rnd_q] = next_key;
        cur_key_d   = next_key;
        if (rnd_q == 4'(NR)) begin
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_DONE: begin
        // done is registered, so it appears together with keys_valid.
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rk_out_d = '0;
    if (rk_idx <= 4'(NR)) begin
      rk_out_d = rk_q[rk_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rnd_q        <= 4'd0;
      cur_key_q    <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      cur_key_q    <= cur_key_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_out_q     <= rk_out_d;
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rk_q[g] <= '0;
      end else begin
        rk_q[g] <= rk_d[g];
      end
    end
  end

  assign busy       = (state_q == ST_EXPAND) || (state_q == ST_DONE);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_out     = rk_out_q;

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequential controller for the AES-128 key schedule. It accepts a 128-bit cipher key through a start handshake and drives one combinational expansion round per clock for rounds 1..10. All 11 round keys are stored in an internal register file, and the cipher datapath reads them by round index. It sits between the key-load interface and the encrypt/decrypt round pipeline, and replaces ten unrolled expansion instances with one shared instance.

## Interface
Parameters:
- NR, 10, number of expansion rounds. Fixed for AES-128; other values are unsupported.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to expand key_in. Sampled only when busy is low.
- key_in  input  [0:127]  cipher key. Byte 0 is in bits [0:7]; word w0 is in bits [0:31].
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when all round keys are valid.
- keys_valid  output  1  high from done until the next accepted start or reset.
- rk_idx  input  4  round-key read index, 0..10.
- rk_out  output  [0:127]  registered round key for rk_idx.

## Operation
- FSM has three states: IDLE, EXPAND, DONE. Reset state is IDLE.
- IDLE, start=1:
  - write key_in to rk[0] and to the working register cur_key;
  - set rnd=1, clear keys_valid, go to EXPAND.
- EXPAND, each cycle:
  - next = expand(cur_key, rnd);
  - write next to rk[rnd] and to cur_key;
  - if rnd==NR, go to DONE; otherwise rnd=rnd+1.
- DONE:
  - assert done for this cycle and set keys_valid;
  - go to IDLE unconditionally.
- expand(k, r):
  - w0' = SubWord(RotWord(k[96:127])) ^ Rcon(r) ^ k[0:31];
  - w1' = w0' ^ k[32:63];
  - w2' = w1' ^ k[64:95];
  - w3' = w2' ^ k[96:127].
- Rcon is indexed by the full 4-bit rnd:
  - rnd 1..10 map to 01,02,04,08,10,20,40,80,1b,36 in the top byte, with the low 24 bits zero;
  - any other rnd value gives 0.
- start while busy, or in DONE, is ignored and not queued.
- Read port: rk_out <= rk[rk_idx] on every clock edge.
  - rk_idx > 10 returns all zeros.
  - Reads during EXPAND return whatever is currently stored, including stale keys. Consumers must gate reads on keys_valid.
- Round-key storage is not cleared on a new start. Only reset clears it.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, rnd=0, busy=0, done=0, keys_valid=0, rk_out=0;
  - rk[0..10] and cur_key cleared to 0.
- start is accepted at edge T (state IDLE). busy is high from T+1 through T+11.
  - rk[n] is written at edge T+n, for n=1..10.
  - done is high for exactly the cycle following edge T+11.
  - keys_valid rises at edge T+11.
- Latency from start acceptance to done is 11 clocks. A new start is accepted no earlier than the cycle after done, which gives 12 clocks per key, minimum.
- busy is derived from state (EXPAND or DONE) and is registered-equivalent.
- Read latency is 1 clock: rk_idx presented in cycle C appears on rk_out in cycle C+1.
- Reset asserted mid-EXPAND aborts immediately. After release the block is in IDLE with keys_valid=0, and no done pulse is issued.

## Structure
- aes_pkg holds:
  - the 256-entry S-box as a function;
  - the Rcon function, indexed 1..10 and returning 0 otherwise;
  - localparams NR=10 and KW=128;
  - the FSM state enum.
- Sub-module aes_key_round: purely combinational, one expansion round, inputs (key[0:127], rnd[3:0]) and output next_key[0:127]. It is instantiated once in this block.
- Top-level contents: FSM, rnd counter, cur_key register, 11×128 round-key register file, registered read mux.

## Test plan
- Apply FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a start pulse:
  - rk[1]=a0fafe1788542cb123a339392a6c7605;
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done 11 cycles after acceptance.
- Apply key all-zero:
  - rk[1]=62636363626363636263636362636363;
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Assert start again 3 cycles after acceptance:
  - ignored; results identical to a single run; exactly one done pulse.
- Assert rst_n low at cycle 5 of EXPAND:
  - all outputs 0 immediately; no done pulse;
  - a subsequent start produces correct keys.
- Read sweep after done with rk_idx=0..15:
  - indices 0..10 match the golden model with 1-cycle latency;
  - indices 11..15 return 0.
- Run two back-to-back keys, with start asserted in the cycle after done:
  - keys_valid drops on the second acceptance;
  - the second key set is correct.
